// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: holds the PC, issues one fetch at a time over a valid/ready
// memory port and hands the instruction, its PC and a fault code to the decoder.
module ysyx_23060203_ifu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    output logic            imem_resp_ready,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [1:0]      out_fault,
    input  logic            next_valid,
    input  logic [XLEN-1:0] next_pc
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        OUT,
        NEXT
    } state_t;

    localparam logic [1:0] FAULT_NONE      = 2'b00;
    localparam logic [1:0] FAULT_ACCESS    = 2'b01;
    localparam logic [1:0] FAULT_MISALIGN  = 2'b10;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst_q;
    logic [1:0]      fault_q;

    // Handshake strobes decode the state register directly, so they change only on clock edges.
    assign imem_req_valid  = (state == REQ);
    assign imem_resp_ready = (state == RESP);
    assign out_valid       = (state == OUT);
    assign imem_req_addr   = pc;
    assign out_pc          = pc;
    assign out_inst        = inst_q;
    assign out_fault       = fault_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            inst_q  <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_req_ready) state <= RESP;
                end
                RESP: begin
                    if (imem_resp_valid) begin
                        state <= OUT;
                        if (imem_resp_err) begin
                            inst_q  <= '0;
                            fault_q <= FAULT_ACCESS;
                        end else begin
                            inst_q  <= imem_resp_data;
                            fault_q <= FAULT_NONE;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) state <= NEXT;
                end
                NEXT: begin
                    if (next_valid) begin
                        pc <= next_pc;
                        // A misaligned target never reaches memory; the fault goes straight to the decoder.
                        if (next_pc[1:0] == 2'b00) begin
                            state <= REQ;
                        end else begin
                            inst_q  <= '0;
                            fault_q <= FAULT_MISALIGN;
                            state   <= OUT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Directed self-checking bench for ysyx_23060203_ifu; memory, decoder and
// writeback partners are driven by hand, one clock at a time.
module tb_ysyx_23060203_ifu;

    logic        clk;
    logic        rstn;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemReqAddr;
    logic        imemRespValid;
    logic        imemRespReady;
    logic [31:0] imemRespData;
    logic        imemRespErr;
    logic        outValid;
    logic        outReady;
    logic [31:0] outInst;
    logic [31:0] outPc;
    logic [1:0]  outFault;
    logic        nextValid;
    logic [31:0] nextPc;

    int checkCount = 0;
    int passCount  = 0;
    int reqHandshakes = 0;
    int outHandshakes = 0;
    int reqBefore;
    int outBefore;

    ysyx_23060203_ifu dut (
        .clk             (clk),
        .rstn            (rstn),
        .imem_req_valid  (imemReqValid),
        .imem_req_ready  (imemReqReady),
        .imem_req_addr   (imemReqAddr),
        .imem_resp_valid (imemRespValid),
        .imem_resp_ready (imemRespReady),
        .imem_resp_data  (imemRespData),
        .imem_resp_err   (imemRespErr),
        .out_valid       (outValid),
        .out_ready       (outReady),
        .out_inst        (outInst),
        .out_pc          (outPc),
        .out_fault       (outFault),
        .next_valid      (nextValid),
        .next_pc         (nextPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed handshakes so stalls can be shown to produce exactly one transfer each.
    always @(posedge clk) begin
        if (rstn && imemReqValid && imemReqReady) reqHandshakes <= reqHandshakes + 1;
        if (rstn && outValid && outReady) outHandshakes <= outHandshakes + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    // Advance one clock; inputs set before the call are sampled at this edge, outputs read 1ns later.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; imemReqReady = 1'b0; imemRespValid = 1'b0; imemRespData = '0;
        imemRespErr = 1'b0; outReady = 1'b0; nextValid = 1'b0; nextPc = '0;
        applyStimulus();
        applyStimulus();
        checkOutput("reset req_valid", {31'b0, imemReqValid}, 32'd0);
        checkOutput("reset resp_ready", {31'b0, imemRespReady}, 32'd0);
        checkOutput("reset out_valid", {31'b0, outValid}, 32'd0);
        checkOutput("reset out_pc", outPc, 32'h8000_0000);
        checkOutput("reset out_inst", outInst, 32'h0);
        checkOutput("reset out_fault", {30'b0, outFault}, 32'd0);

        // Release reset: one idle cycle, then the first request.
        rstn = 1'b1;
        applyStimulus();
        checkOutput("first req_valid", {31'b0, imemReqValid}, 32'd1);
        checkOutput("first req_addr", imemReqAddr, 32'h8000_0000);
        checkOutput("req resp_ready low", {31'b0, imemRespReady}, 32'd0);
        imemReqReady = 1'b1;
        applyStimulus();
        imemReqReady = 1'b0;
        checkOutput("resp resp_ready", {31'b0, imemRespReady}, 32'd1);
        checkOutput("resp req_valid low", {31'b0, imemReqValid}, 32'd0);
        imemRespValid = 1'b1; imemRespData = 32'h0000_0013;
        applyStimulus();
        imemRespValid = 1'b0;
        checkOutput("first out_valid", {31'b0, outValid}, 32'd1);
        checkOutput("first out_inst", outInst, 32'h0000_0013);
        checkOutput("first out_pc", outPc, 32'h8000_0000);
        checkOutput("first out_fault", {30'b0, outFault}, 32'd0);

        // next_valid during OUT must not touch pc.
        nextValid = 1'b1; nextPc = 32'h1234_5678;
        applyStimulus();
        nextValid = 1'b0;
        checkOutput("ignored next out_pc", outPc, 32'h8000_0000);
        checkOutput("ignored next out_valid", {31'b0, outValid}, 32'd1);
        outReady = 1'b1;
        applyStimulus();
        outReady = 1'b0;
        checkOutput("next out_valid low", {31'b0, outValid}, 32'd0);
        checkOutput("next req_valid low", {31'b0, imemReqValid}, 32'd0);
        nextValid = 1'b1; nextPc = 32'h8000_0004;
        applyStimulus();
        nextValid = 1'b0;
        checkOutput("seq req_valid", {31'b0, imemReqValid}, 32'd1);
        checkOutput("seq req_addr", imemReqAddr, 32'h8000_0004);

        // Backpressure on every interface.
        reqBefore = reqHandshakes;
        outBefore = outHandshakes;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("stall req_valid", {31'b0, imemReqValid}, 32'd1);
            checkOutput("stall req_addr", imemReqAddr, 32'h8000_0004);
        end
        imemReqReady = 1'b1;
        applyStimulus();
        imemReqReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            checkOutput("wait resp_ready", {31'b0, imemRespReady}, 32'd1);
            checkOutput("wait out_valid low", {31'b0, outValid}, 32'd0);
        end
        imemRespValid = 1'b1; imemRespData = 32'h0010_0093;
        applyStimulus();
        imemRespData = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            imemRespValid = 1'b0;
            checkOutput("stall out_valid", {31'b0, outValid}, 32'd1);
            checkOutput("stall out_inst", outInst, 32'h0010_0093);
            checkOutput("stall out_pc", outPc, 32'h8000_0004);
        end
        outReady = 1'b1;
        applyStimulus();
        outReady = 1'b0;
        checkOutput("req handshakes", reqHandshakes - reqBefore, 32'd1);
        checkOutput("out handshakes", outHandshakes - outBefore, 32'd1);

        // Access fault.
        nextValid = 1'b1; nextPc = 32'h8000_0008;
        applyStimulus();
        nextValid = 1'b0; imemReqReady = 1'b1;
        applyStimulus();
        imemReqReady = 1'b0; imemRespValid = 1'b1; imemRespErr = 1'b1; imemRespData = 32'hDEAD_BEEF;
        applyStimulus();
        imemRespValid = 1'b0; imemRespErr = 1'b0;
        checkOutput("err out_valid", {31'b0, outValid}, 32'd1);
        checkOutput("err out_inst", outInst, 32'h0);
        checkOutput("err out_fault", {30'b0, outFault}, 32'd1);
        checkOutput("err out_pc", outPc, 32'h8000_0008);
        outReady = 1'b1;
        applyStimulus();
        outReady = 1'b0;

        // Misaligned target goes straight to OUT.
        reqBefore = reqHandshakes;
        imemReqReady = 1'b1;
        nextValid = 1'b1; nextPc = 32'h8000_0006;
        applyStimulus();
        nextValid = 1'b0;
        checkOutput("misalign req_valid", {31'b0, imemReqValid}, 32'd0);
        checkOutput("misalign out_valid", {31'b0, outValid}, 32'd1);
        checkOutput("misalign out_pc", outPc, 32'h8000_0006);
        checkOutput("misalign out_fault", {30'b0, outFault}, 32'd2);
        checkOutput("misalign out_inst", outInst, 32'h0);
        imemReqReady = 1'b0;
        outReady = 1'b1;
        applyStimulus();
        outReady = 1'b0;
        checkOutput("misalign no req", reqHandshakes - reqBefore, 32'd0);

        // Reset while waiting for a response; the stale response must be dropped.
        nextValid = 1'b1; nextPc = 32'h8000_000C;
        applyStimulus();
        nextValid = 1'b0; imemReqReady = 1'b1;
        applyStimulus();
        imemReqReady = 1'b0;
        checkOutput("pre-reset resp_ready", {31'b0, imemRespReady}, 32'd1);
        rstn = 1'b0; imemRespValid = 1'b1; imemRespData = 32'h0BAD_0BAD;
        applyStimulus();
        rstn = 1'b1;
        checkOutput("midreset resp_ready", {31'b0, imemRespReady}, 32'd0);
        checkOutput("midreset req_valid", {31'b0, imemReqValid}, 32'd0);
        checkOutput("midreset out_pc", outPc, 32'h8000_0000);
        applyStimulus();
        checkOutput("restart req_addr", imemReqAddr, 32'h8000_0000);
        checkOutput("restart resp_ready", {31'b0, imemRespReady}, 32'd0);
        checkOutput("restart out_inst", outInst, 32'h0);
        imemRespValid = 1'b0; imemReqReady = 1'b1;
        applyStimulus();
        imemReqReady = 1'b0; imemRespValid = 1'b1; imemRespData = 32'h0000_0513;
        applyStimulus();
        imemRespValid = 1'b0;
        checkOutput("restart out_inst", outInst, 32'h0000_0513);
        checkOutput("restart out_fault", {30'b0, outFault}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
